// File: rtl/sme_string_match.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sme_string_match: string buffer (32 chars) searched for patterns of up to  |
// | 8 chars with '^', '$', '.' and, when SME_STAR_EN is defined, '*'.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sme_string_match (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] chardata,
  input  logic       isstring,
  input  logic       ispattern,
  output logic       valid,
  output logic       match,
  output logic [4:0] match_index
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD_STR = 3'd1;
  localparam logic [2:0] S_LOAD_PAT = 3'd2;
  localparam logic [2:0] S_MATCH    = 3'd3;
  localparam logic [2:0] S_DONE     = 3'd4;

  localparam logic [7:0] C_CARET  = 8'h5E;
  localparam logic [7:0] C_DOLLAR = 8'h24;
  localparam logic [7:0] C_DOT    = 8'h2E;
  localparam logic [7:0] C_SPACE  = 8'h20;
`ifdef SME_STAR_EN
  localparam logic [7:0] C_STAR   = 8'h2A;
`endif

  logic [2:0] r_state, w_next;
  logic [7:0] r_str [32];
  logic [7:0] r_pat [8];
  logic [5:0] r_str_len;
  logic [3:0] r_pat_len;
  logic [5:0] r_pos;
  logic [4:0] r_start;
  logic       r_phase;
  logic       r_match;
  logic [4:0] r_index;

  logic       w_str_wr, w_pat_wr;
  logic       w_caret, w_dollar;
  logic [3:0] w_caret_n, w_dollar_n;
  logic       w_has_star;
  logic [3:0] w_star_pos;
  logic [3:0] w_seg_b, w_seg_n, w_pre_n;
  logic       w_chk_caret, w_chk_dollar;
  logic [6:0] w_end;
  logic       w_fit, w_seg_eq, w_caret_ok, w_dollar_ok;
  logic       w_hit, w_exhausted, w_found, w_finish;

  assign w_str_wr = isstring && (r_state == S_IDLE || r_state == S_LOAD_STR);
  assign w_pat_wr = ispattern && (r_state == S_IDLE || r_state == S_LOAD_STR ||
                                  r_state == S_LOAD_PAT);

  // A lone '^' is an anchor, never also a trailing '$'.
  assign w_caret    = (r_pat_len != 4'd0) && (r_pat[0] == C_CARET);
  assign w_dollar   = (r_pat_len != 4'd0) && (r_pat[3'(r_pat_len - 4'd1)] == C_DOLLAR) &&
                      !((r_pat_len == 4'd1) && w_caret);
  assign w_caret_n  = {3'b000, w_caret};
  assign w_dollar_n = {3'b000, w_dollar};

`ifdef SME_STAR_EN
  always_comb begin
    w_has_star = 1'b0;
    w_star_pos = 4'd0;
    for (int k = 7; k >= 0; k--) begin
      if ((4'(k) < r_pat_len) && (r_pat[3'(k)] == C_STAR)) begin
        w_has_star = 1'b1;
        w_star_pos = 4'(k);
      end
    end
  end
`else
  assign w_has_star = 1'b0;
  assign w_star_pos = 4'd0;
`endif

  assign w_pre_n = w_star_pos - w_caret_n;

  // Phase 0 scans the prefix (or whole pattern); phase 1 scans the suffix after '*'.
  always_comb begin
    w_seg_b      = w_caret_n;
    w_seg_n      = r_pat_len - w_caret_n - w_dollar_n;
    w_chk_caret  = w_caret;
    w_chk_dollar = w_dollar;
    if (w_has_star) begin
      if (!r_phase) begin
        w_seg_n      = w_pre_n;
        w_chk_dollar = 1'b0;
      end else begin
        w_seg_b     = w_star_pos + 4'd1;
        w_seg_n     = r_pat_len - w_dollar_n - w_star_pos - 4'd1;
        w_chk_caret = 1'b0;
      end
    end
  end

  assign w_end = {1'b0, r_pos} + {3'b000, w_seg_n};
  assign w_fit = (w_end <= {1'b0, r_str_len});

  always_comb begin
    w_seg_eq = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (4'(k) < w_seg_n) begin
        if ((r_pat[3'(w_seg_b + 4'(k))] != C_DOT) &&
            (r_pat[3'(w_seg_b + 4'(k))] != r_str[5'(r_pos + 6'(k))]))
          w_seg_eq = 1'b0;
      end
    end
  end

  assign w_caret_ok  = !w_chk_caret || (r_pos == 6'd0) ||
                       (r_str[5'(r_pos - 6'd1)] == C_SPACE);
  assign w_dollar_ok = !w_chk_dollar || (w_end == {1'b0, r_str_len}) ||
                       (r_str[w_end[4:0]] == C_SPACE);
  assign w_hit       = w_fit && w_seg_eq && w_caret_ok && w_dollar_ok;
  assign w_exhausted = (r_pos >= r_str_len);
  assign w_found     = w_hit && (!w_has_star || r_phase);
  assign w_finish    = w_found || (!w_hit && w_exhausted);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (isstring)       w_next = S_LOAD_STR;
        else if (ispattern) w_next = S_LOAD_PAT;
      end
      S_LOAD_STR: begin
        if (ispattern)      w_next = S_LOAD_PAT;
        else if (!isstring) w_next = S_IDLE;
      end
      S_LOAD_PAT: if (!ispattern) w_next = S_MATCH;
      S_MATCH:    if (w_finish)   w_next = S_DONE;
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_comb begin
    valid       = (r_state == S_DONE);
    match       = valid && r_match;
    match_index = valid ? r_index : 5'd0;
  end

  always_ff @(posedge clk) begin
    if (w_str_wr) begin
      if (r_state != S_LOAD_STR)  r_str[0] <= chardata;
      else if (r_str_len < 6'd32) r_str[r_str_len[4:0]] <= chardata;
    end
    if (w_pat_wr) begin
      if (r_state != S_LOAD_PAT) r_pat[0] <= chardata;
      else if (r_pat_len < 4'd8) r_pat[r_pat_len[2:0]] <= chardata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_str_len <= 6'd0;
      r_pat_len <= 4'd0;
      r_pos     <= 6'd0;
      r_start   <= 5'd0;
      r_phase   <= 1'b0;
      r_match   <= 1'b0;
      r_index   <= 5'd0;
    end else begin
      if (w_str_wr) begin
        if (r_state != S_LOAD_STR)  r_str_len <= 6'd1;
        else if (r_str_len < 6'd32) r_str_len <= r_str_len + 6'd1;
      end
      if (w_pat_wr) begin
        if (r_state != S_LOAD_PAT) r_pat_len <= 4'd1;
        else if (r_pat_len < 4'd8) r_pat_len <= r_pat_len + 4'd1;
        r_pos   <= 6'd0;
        r_phase <= 1'b0;
        r_match <= 1'b0;
        r_index <= 5'd0;
      end
      if (r_state == S_MATCH) begin
        if (w_hit && w_has_star && !r_phase) begin
          r_phase <= 1'b1;
          r_start <= r_pos[4:0];
          r_pos   <= w_end[5:0];
        end else if (w_found) begin
          r_match <= 1'b1;
          if (!w_has_star)           r_index <= r_pos[4:0];
          else if (w_pre_n != 4'd0)  r_index <= r_start;
          else if (w_seg_n != 4'd0)  r_index <= r_pos[4:0];
          else                       r_index <= 5'd0;
        end else if (!w_exhausted) begin
          r_pos <= r_pos + 6'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sme_string_match.sv
`default_nettype none
// Directed bench for sme_string_match: literal, anchor, wildcard, star,
// reset-abort and back-to-back scenarios with hand-computed results.
module tb_sme_string_match;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] chardata;
  logic       isstring;
  logic       ispattern;
  logic       valid;
  logic       match;
  logic [4:0] match_index;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sme_string_match dut (
    .clk         (clk),
    .reset       (reset),
    .chardata    (chardata),
    .isstring    (isstring),
    .ispattern   (ispattern),
    .valid       (valid),
    .match       (match),
    .match_index (match_index)
  );

  task automatic load_string(input string s);
    for (int i = 0; i < s.len(); i++) begin
      isstring = 1'b1;
      chardata = s[i];
      @(posedge clk); #1;
    end
    isstring = 1'b0;
    chardata = 8'h00;
  endtask

  // Drives a pattern, waits for valid, then samples the following cycle.
  task automatic run_pattern(input string p, output bit got, output logic m,
                             output logic [4:0] ix, output int lat, output bit clean);
    got = 1'b0; m = 1'b0; ix = 5'd0; lat = 0; clean = 1'b0;
    for (int i = 0; i < p.len(); i++) begin
      ispattern = 1'b1;
      chardata  = p[i];
      @(posedge clk); #1;
    end
    ispattern = 1'b0;
    chardata  = 8'h00;
    for (int c = 1; c <= 100 && !got; c++) begin
      @(posedge clk); #1;
      if (valid === 1'b1) begin
        got = 1'b1; m = match; ix = match_index; lat = c;
      end
    end
    if (got) begin
      @(posedge clk); #1;
      clean = (valid === 1'b0) && (match === 1'b0) && (match_index === 5'd0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; isstring = 1'b0; ispattern = 1'b0; chardata = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (valid !== 1'b0) begin miscompares++; $display("FAIL reset valid: got %b want 0", valid); end
    vectors++;
    if (match !== 1'b0) begin miscompares++; $display("FAIL reset match: got %b want 0", match); end
    vectors++;
    if (match_index !== 5'd0) begin miscompares++; $display("FAIL reset index: got %0d want 0", match_index); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_literal();
    string pats [6] = '{"quick", "q.i", "cat", "e quick ", "fox ", "."};
    bit    em   [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    int    ei   [6] = '{4, 4, 0, 2, 0, 0};
    bit got, clean; logic m; logic [4:0] ix; int lat;
    load_string("the quick brown fox");
    foreach (pats[i]) begin
      run_pattern(pats[i], got, m, ix, lat, clean);
      vectors++;
      if (!got) begin miscompares++; $display("FAIL literal '%s' timeout: no valid in 100 cycles", pats[i]); continue; end
      vectors++;
      if (m !== em[i]) begin miscompares++; $display("FAIL literal '%s' match: got %b want %b", pats[i], m, em[i]); end
      vectors++;
      if (ix !== 5'(ei[i])) begin miscompares++; $display("FAIL literal '%s' index: got %0d want %0d", pats[i], ix, ei[i]); end
      vectors++;
      if (!clean) begin miscompares++; $display("FAIL literal '%s' pulse: outputs not 0 after valid", pats[i]); end
      vectors++;
      if (lat > 80) begin miscompares++; $display("FAIL literal '%s' latency: got %0d want <=80", pats[i], lat); end
    end
  endtask

  task automatic test_anchors();
    string pats [6] = '{"^bro", "^own", "fox$", "quick$", "qui$", "^the"};
    bit    em   [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int    ei   [6] = '{10, 0, 16, 4, 0, 0};
    bit got, clean; logic m; logic [4:0] ix; int lat;
    foreach (pats[i]) begin
      run_pattern(pats[i], got, m, ix, lat, clean);
      vectors++;
      if (!got) begin miscompares++; $display("FAIL anchor '%s' timeout: no valid in 100 cycles", pats[i]); continue; end
      vectors++;
      if (m !== em[i]) begin miscompares++; $display("FAIL anchor '%s' match: got %b want %b", pats[i], m, em[i]); end
      vectors++;
      if (ix !== 5'(ei[i])) begin miscompares++; $display("FAIL anchor '%s' index: got %0d want %0d", pats[i], ix, ei[i]); end
      vectors++;
      if (!clean) begin miscompares++; $display("FAIL anchor '%s' pulse: outputs not 0 after valid", pats[i]); end
    end
  endtask

  task automatic test_star();
`ifdef SME_STAR_EN
    string pats [4] = '{"qu*fox", "z*x", "^b*n$", "*fox"};
    bit    em   [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    int    ei   [4] = '{4, 0, 10, 16};
`else
    string pats [4] = '{"qu*fox", "z*x", "^b*n$", "k*"};
    bit    em   [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    int    ei   [4] = '{0, 0, 0, 0};
`endif
    bit got, clean; logic m; logic [4:0] ix; int lat;
    foreach (pats[i]) begin
      run_pattern(pats[i], got, m, ix, lat, clean);
      vectors++;
      if (!got) begin miscompares++; $display("FAIL star '%s' timeout: no valid in 100 cycles", pats[i]); continue; end
      vectors++;
      if (m !== em[i]) begin miscompares++; $display("FAIL star '%s' match: got %b want %b", pats[i], m, em[i]); end
      vectors++;
      if (ix !== 5'(ei[i])) begin miscompares++; $display("FAIL star '%s' index: got %0d want %0d", pats[i], ix, ei[i]); end
      vectors++;
      if (lat > 80) begin miscompares++; $display("FAIL star '%s' latency: got %0d want <=80", pats[i], lat); end
    end
  endtask

  task automatic test_reset_abort();
    bit got, clean, seen; logic m; logic [4:0] ix; int lat;
    string part = "qu";
    // Abort during pattern load.
    for (int i = 0; i < part.len(); i++) begin
      ispattern = 1'b1; chardata = part[i];
      @(posedge clk); #1;
    end
    ispattern = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 90; c++) begin
      @(posedge clk); #1;
      if (valid !== 1'b0 || match !== 1'b0 || match_index !== 5'd0) seen = 1'b1;
    end
    vectors++;
    if (seen) begin miscompares++; $display("FAIL abort_load outputs: got activity want all 0"); end
    // Abort during matching.
    load_string("aaab");
    ispattern = 1'b1; chardata = "z"; @(posedge clk); #1;
    chardata = "z"; @(posedge clk); #1;
    ispattern = 1'b0; chardata = 8'h00;
    @(posedge clk); #1;
    reset = 1'b1; @(posedge clk); #1;
    reset = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 90; c++) begin
      @(posedge clk); #1;
      if (valid !== 1'b0) seen = 1'b1;
    end
    vectors++;
    if (seen) begin miscompares++; $display("FAIL abort_match valid: got pulse want none"); end
    load_string("aaab");
    run_pattern("ab$", got, m, ix, lat, clean);
    vectors++;
    if (!got) begin miscompares++; $display("FAIL reload 'ab$' timeout: no valid in 100 cycles"); end
    else begin
      vectors++;
      if (m !== 1'b1) begin miscompares++; $display("FAIL reload 'ab$' match: got %b want 1", m); end
      vectors++;
      if (ix !== 5'd2) begin miscompares++; $display("FAIL reload 'ab$' index: got %0d want 2", ix); end
    end
  endtask

  task automatic test_back_to_back();
    string strs [4] = '{"ab cab", "", "xyz", ""};
    string pats [4] = '{"^cab$", "b", "z$", "ab"};
    bit    em   [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    int    ei   [4] = '{3, 1, 2, 0};
    bit got, clean; logic m; logic [4:0] ix; int lat;
    foreach (pats[i]) begin
      if (strs[i].len() != 0) load_string(strs[i]);
      run_pattern(pats[i], got, m, ix, lat, clean);
      vectors++;
      if (!got) begin miscompares++; $display("FAIL b2b '%s' timeout: no valid in 100 cycles", pats[i]); continue; end
      vectors++;
      if (m !== em[i]) begin miscompares++; $display("FAIL b2b '%s' match: got %b want %b", pats[i], m, em[i]); end
      vectors++;
      if (ix !== 5'(ei[i])) begin miscompares++; $display("FAIL b2b '%s' index: got %0d want %0d", pats[i], ix, ei[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_literal();
    test_anchors();
    test_star();
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
